// File: rtl/dcache_pkg.sv
// dcache_pkg: shared field widths, tag-word bit positions and FSM states for the data-cache controller
package dcache_pkg;
   localparam int TAG_W     = 23;
   localparam int IDX_W     = 4;
   localparam int OFS_W     = 5;
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;
   localparam int LINE_W    = 256;
   typedef enum logic [2:0] {
      S_IDLE,
      S_MISS,
      S_WRITEBACK,
      S_REFILL,
      S_REFILL_DONE
   } state_t;
endpackage

// File: rtl/dcache_word_mux.sv
// dcache_word_mux: extracts the selected 32-bit word of a line and builds the line with that word replaced
module dcache_word_mux
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line,
   input  logic [2:0]        sel,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [LINE_W-1:0] merged
);
   logic [7:0] sh;
   assign sh     = {sel, 5'b0};
   assign rdata  = line[sh +: 32];
   assign merged = (line & ~({{(LINE_W-32){1'b0}}, 32'hFFFF_FFFF} << sh))
                 | ({{(LINE_W-32){1'b0}}, wdata} << sh);
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back data-cache controller serving hits from the SRAM and running write-back/refill on misses
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   input  logic              cpu_mem_read_i,
   input  logic              cpu_mem_write_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   output logic [IDX_W-1:0]  sram_addr_o,
   output logic [24:0]       sram_tag_o,
   output logic [LINE_W-1:0] sram_data_o,
   output logic              sram_enable_o,
   output logic              sram_write_o,
   input  logic [24:0]       sram_tag_i,
   input  logic [LINE_W-1:0] sram_data_i,
   input  logic              sram_hit_i,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);
   state_t state, state_nxt;
   logic [LINE_W-1:0] line_buf, merged;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic req, idle, fill;
   logic unused_ok;
   assign req       = cpu_mem_read_i | cpu_mem_write_i;
   assign idx       = cpu_addr_i[OFS_W +: IDX_W];
   assign tag       = cpu_addr_i[31 -: TAG_W];
   assign idle      = state == S_IDLE;
   assign fill      = state == S_REFILL_DONE;
   assign unused_ok = &{1'b0, cpu_addr_i[1:0]};
   dcache_word_mux u_word_mux (
      .line   (sram_data_i),
      .sel    (cpu_addr_i[4:2]),
      .wdata  (cpu_data_i),
      .rdata  (cpu_data_o),
      .merged (merged)
   );
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= S_IDLE;
         line_buf <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_REFILL && mem_ack_i) line_buf <= mem_data_i;
      end
   end
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      state_nxt = req && !sram_hit_i ? S_MISS : S_IDLE;
         S_MISS:      state_nxt = sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT] ? S_WRITEBACK : S_REFILL;
         S_WRITEBACK: state_nxt = mem_ack_i ? S_REFILL : S_WRITEBACK;
         S_REFILL:    state_nxt = mem_ack_i ? S_REFILL_DONE : S_REFILL;
         default:     state_nxt = S_IDLE;
      endcase
   end
   assign cpu_stall_o   = idle ? req & ~sram_hit_i : 1'b1;
   assign sram_addr_o   = idx;
   assign sram_enable_o = req | ~idle;
   assign sram_write_o  = idle ? req & cpu_mem_write_i & sram_hit_i : fill;
   // a freshly filled line is clean; a store hit marks it dirty
   assign sram_tag_o    = {1'b1, ~fill, tag};
   assign sram_data_o   = fill ? line_buf : merged;
   assign mem_enable_o  = state == S_WRITEBACK || state == S_REFILL;
   assign mem_write_o   = state == S_WRITEBACK;
   assign mem_addr_o    = mem_write_o ? {sram_tag_i[TAG_W-1:0], idx, 5'b0}
                        : state == S_REFILL ? {cpu_addr_i[31:5], 5'b0} : 32'h0;
   assign mem_data_o    = mem_write_o ? sram_data_i : '0;
endmodule
